// File: rtl/mem_io_unit.sv
// Memory/IO unit: word RAM, kernel-only OS region, memory-mapped output channels
// and FIFO-buffered input channels with sticky fault capture. Option: MEMIO_OUT_READBACK_EN.
module mem_io_unit #(
  parameter int              DATA_W   = 16,
  parameter int              ADDR_W   = 16,
  parameter int              RAM_AW   = 10,
  parameter logic [ADDR_W-1:0] RAM_BASE = ADDR_W'(16'h4000),
  parameter logic [ADDR_W-1:0] OS_LO    = ADDR_W'(16'h1000),
  parameter logic [ADDR_W-1:0] OS_HI    = ADDR_W'(16'h3FFF),
  parameter logic [ADDR_W-1:0] OUT_BASE = ADDR_W'(16'h0000),
  parameter logic [ADDR_W-1:0] IN_BASE  = ADDR_W'(16'h0100),
  parameter int              IO_CH    = 4,
  parameter int              IN_DEPTH = 4
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [ADDR_W-1:0]         Addr,
  input  logic [DATA_W-1:0]         WriteData,
  input  logic                      WriteFlag,
  input  logic                      ReadFlag,
  input  logic                      KernelFlag,
  output logic [DATA_W-1:0]         ReadData,
  output logic                      ReadValid,
  output logic                      AccInv,
  output logic [ADDR_W-1:0]         FaultAddr,
  input  logic                      FaultClr,
  output logic [IO_CH*DATA_W-1:0]   Output,
  output logic [IO_CH-1:0]          OutStrobe,
  input  logic [IO_CH*DATA_W-1:0]   Input,
  input  logic [IO_CH-1:0]          InputStrobe,
  output logic [IO_CH-1:0]          InputRecv,
  output logic [IO_CH-1:0]          InputFull,
  output logic [IO_CH-1:0]          InputOvf,
  input  logic [IO_CH-1:0]          InputRst
);

  localparam int CH_W      = (IO_CH > 1) ? $clog2(IO_CH) : 1;
  localparam int PW        = $clog2(IN_DEPTH);
  localparam int CW        = PW + 1;
  localparam int RAM_WORDS = 1 << RAM_AW;
  localparam logic [ADDR_W-1:0] CH_SPAN  = ADDR_W'(2 * IO_CH);
  localparam logic [ADDR_W:0]   RAM_SPAN = (ADDR_W + 1)'(2 ** (RAM_AW + 1));

  logic [DATA_W-1:0]       r_ram [RAM_WORDS];
  logic [DATA_W-1:0]       r_os  [RAM_WORDS];
  logic [DATA_W-1:0]       r_rd_data;
  logic                    r_rd_valid;
  logic                    r_acc_inv;
  logic [ADDR_W-1:0]       r_fault_addr;
  logic [IO_CH*DATA_W-1:0] r_out;
  logic [IO_CH-1:0]        r_strobe;

  logic                    w_wr, w_rd, w_req;
  logic [ADDR_W-1:0]       w_out_off, w_in_off, w_ram_off;
  logic                    w_out_hit, w_in_hit, w_os_hit, w_ram_hit, w_mapped;
  logic                    w_fault, w_wr_ok, w_rd_ok;
  logic [CH_W-1:0]         w_out_ch, w_in_ch;
  logic [RAM_AW-1:0]       w_ram_idx, w_os_idx;
  logic [DATA_W-1:0]       w_rd_data;
  logic [IO_CH*DATA_W-1:0] w_head;
  logic [IO_CH-1:0]        w_recv, w_full, w_ovf;

  // A simultaneous read and write is treated as a write only
  assign w_wr  = WriteFlag;
  assign w_rd  = ReadFlag & ~WriteFlag;
  assign w_req = ReadFlag | WriteFlag;

  // Offsets wrap below each base, so a single upper-bound compare decodes each window
  assign w_out_off = Addr - OUT_BASE;
  assign w_in_off  = Addr - IN_BASE;
  assign w_ram_off = Addr - RAM_BASE;
  assign w_out_hit = (w_out_off < CH_SPAN);
  assign w_in_hit  = (w_in_off < CH_SPAN);
  assign w_os_hit  = (Addr >= OS_LO) && (Addr <= OS_HI);
  assign w_ram_hit = ({1'b0, w_ram_off} < RAM_SPAN);
  assign w_mapped  = w_out_hit | w_in_hit | w_os_hit | w_ram_hit;

  assign w_out_ch  = CH_W'(w_out_off >> 1);
  assign w_in_ch   = CH_W'(w_in_off >> 1);
  assign w_ram_idx = RAM_AW'(w_ram_off >> 1);
  assign w_os_idx  = RAM_AW'((Addr - OS_LO) >> 1);

  assign w_fault = w_req & (Addr[0] | ~w_mapped | (w_os_hit & ~KernelFlag) | (w_wr & w_in_hit));
  assign w_wr_ok = w_wr & ~w_fault;
  assign w_rd_ok = w_rd & ~w_fault;

  // Load data selection; faulting reads and empty/flushed FIFOs return zero
  always_comb begin
    w_rd_data = '0;
    if (w_fault) begin
      w_rd_data = '0;
    end else if (w_out_hit) begin
`ifdef MEMIO_OUT_READBACK_EN
      w_rd_data = r_out[w_out_ch*DATA_W +: DATA_W];
`else
      w_rd_data = '0;
`endif
    end else if (w_in_hit) begin
      if (w_recv[w_in_ch] && !InputRst[w_in_ch]) begin
        w_rd_data = w_head[w_in_ch*DATA_W +: DATA_W];
      end else begin
        w_rd_data = '0;
      end
    end else if (w_os_hit) begin
      w_rd_data = r_os[w_os_idx];
    end else if (w_ram_hit) begin
      w_rd_data = r_ram[w_ram_idx];
    end else begin
      w_rd_data = '0;
    end
  end

  // Storage arrays are deliberately not reset; the OS region is its own array so user RAM never aliases it
  always_ff @(posedge Clk) begin
    if (w_wr_ok && w_ram_hit) begin
      r_ram[w_ram_idx] <= WriteData;
    end
    if (w_wr_ok && w_os_hit) begin
      r_os[w_os_idx] <= WriteData;
    end
  end

  // Registered load response; data holds until the next read
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd;
      if (w_rd) begin
        r_rd_data <= w_rd_data;
      end
    end
  end

  // Sticky fault: first fault wins, but a fault alongside FaultClr replaces the old one
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_acc_inv    <= 1'b0;
      r_fault_addr <= '0;
    end else if (w_fault) begin
      r_acc_inv <= 1'b1;
      if (!r_acc_inv || FaultClr) begin
        r_fault_addr <= Addr;
      end
    end else if (FaultClr) begin
      r_acc_inv    <= 1'b0;
      r_fault_addr <= '0;
    end
  end

  // Output channel registers and their one-cycle write strobes
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_out    <= '0;
      r_strobe <= '0;
    end else begin
      r_strobe <= '0;
      if (w_wr_ok && w_out_hit) begin
        r_out[w_out_ch*DATA_W +: DATA_W] <= WriteData;
        r_strobe[w_out_ch]               <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < IO_CH; i++) begin : g_ch
    logic [DATA_W-1:0] r_mem [IN_DEPTH];
    logic [PW-1:0]     r_wp, r_rp;
    logic [CW-1:0]     r_cnt;
    logic              r_recv, r_full, r_ovf;
    logic              w_pop, w_do_push;
    logic [CW-1:0]     w_cnt_nxt;

    assign w_pop     = w_rd_ok & w_in_hit & (w_in_ch == CH_W'(i)) & r_recv;
    assign w_do_push = InputStrobe[i] & (~r_full | w_pop);

    // Next occupancy from the accepted push and pop
    always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_do_push && !w_pop) begin
        w_cnt_nxt = r_cnt + CW'(1);
      end else if (!w_do_push && w_pop) begin
        w_cnt_nxt = r_cnt - CW'(1);
      end else begin
        w_cnt_nxt = r_cnt;
      end
    end

    // FIFO state; a per-channel flush overrides any same-cycle push or pop
    always_ff @(posedge Clk) begin
      if (Rst || InputRst[i]) begin
        r_wp   <= '0;
        r_rp   <= '0;
        r_cnt  <= '0;
        r_recv <= 1'b0;
        r_full <= 1'b0;
        r_ovf  <= 1'b0;
      end else begin
        if (w_do_push) begin
          r_mem[r_wp] <= Input[i*DATA_W +: DATA_W];
          r_wp        <= r_wp + PW'(1);
        end
        if (w_pop) begin
          r_rp <= r_rp + PW'(1);
        end
        r_cnt  <= w_cnt_nxt;
        r_recv <= (w_cnt_nxt != '0);
        r_full <= (w_cnt_nxt == CW'(IN_DEPTH));
        if (InputStrobe[i] && !w_do_push) begin
          r_ovf <= 1'b1;
        end
      end
    end

    assign w_head[i*DATA_W +: DATA_W] = r_mem[r_rp];
    assign w_recv[i] = r_recv;
    assign w_full[i] = r_full;
    assign w_ovf[i]  = r_ovf;
  end

  assign ReadData  = r_rd_data;
  assign ReadValid = r_rd_valid;
  assign AccInv    = r_acc_inv;
  assign FaultAddr = r_fault_addr;
  assign Output    = r_out;
  assign OutStrobe = r_strobe;
  assign InputRecv = w_recv;
  assign InputFull = w_full;
  assign InputOvf  = w_ovf;

endmodule

// File: tb/tb_mem_io_unit.sv
// Directed self-checking bench for mem_io_unit (default parameters).
module tb_mem_io_unit;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [15:0] Addr = 16'h0000;
  logic [15:0] WriteData = 16'h0000;
  logic        WriteFlag = 1'b0;
  logic        ReadFlag = 1'b0;
  logic        KernelFlag = 1'b0;
  logic [15:0] ReadData;
  logic        ReadValid;
  logic        AccInv;
  logic [15:0] FaultAddr;
  logic        FaultClr = 1'b0;
  logic [63:0] Output;
  logic [3:0]  OutStrobe;
  logic [63:0] Input = 64'h0;
  logic [3:0]  InputStrobe = 4'h0;
  logic [3:0]  InputRecv;
  logic [3:0]  InputFull;
  logic [3:0]  InputOvf;
  logic [3:0]  InputRst = 4'h0;

  int total = 0;
  int bad = 0;

  mem_io_unit dut (
    .Clk(Clk), .Rst(Rst), .Addr(Addr), .WriteData(WriteData),
    .WriteFlag(WriteFlag), .ReadFlag(ReadFlag), .KernelFlag(KernelFlag),
    .ReadData(ReadData), .ReadValid(ReadValid), .AccInv(AccInv),
    .FaultAddr(FaultAddr), .FaultClr(FaultClr), .Output(Output),
    .OutStrobe(OutStrobe), .Input(Input), .InputStrobe(InputStrobe),
    .InputRecv(InputRecv), .InputFull(InputFull), .InputOvf(InputOvf),
    .InputRst(InputRst)
  );

  always #5 Clk = ~Clk;

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic k);
    Addr = a; WriteData = d; KernelFlag = k; WriteFlag = 1'b1;
    cyc();
    WriteFlag = 1'b0; KernelFlag = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic k);
    Addr = a; KernelFlag = k; ReadFlag = 1'b1;
    cyc();
    ReadFlag = 1'b0; KernelFlag = 1'b0;
  endtask

  task automatic push(input int ch, input logic [15:0] d);
    Input[ch*16 +: 16] = d; InputStrobe[ch] = 1'b1;
    cyc();
    InputStrobe = 4'h0;
  endtask

  task automatic clr_fault();
    FaultClr = 1'b1;
    cyc();
    FaultClr = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1; cyc(); cyc(); Rst = 1'b0;
    total++; if ({ReadData, ReadValid} !== 17'h0) begin bad++; $display("FAIL reset_read: got %h/%b want 0000/0", ReadData, ReadValid); end
    total++; if ({AccInv, FaultAddr} !== 17'h0) begin bad++; $display("FAIL reset_fault: got %b/%h want 0/0000", AccInv, FaultAddr); end
    total++; if ({Output, OutStrobe} !== 68'h0) begin bad++; $display("FAIL reset_out: got %h/%b want 0", Output, OutStrobe); end
    total++; if ({InputRecv, InputFull, InputOvf} !== 12'h0) begin bad++; $display("FAIL reset_in: got %b/%b/%b want 0", InputRecv, InputFull, InputOvf); end
  endtask

  task automatic test_ram();
    wr(16'h4000, 16'h1234, 1'b0);
    wr(16'h4002, 16'h4321, 1'b0);
    rd(16'h4000, 1'b0);
    total++; if ({ReadValid, ReadData} !== {1'b1, 16'h1234}) begin bad++; $display("FAIL ram_rd0: got %b/%h want 1/1234", ReadValid, ReadData); end
    rd(16'h4002, 1'b0);
    total++; if ({ReadValid, ReadData} !== {1'b1, 16'h4321}) begin bad++; $display("FAIL ram_rd1: got %b/%h want 1/4321", ReadValid, ReadData); end
    cyc();
    total++; if ({ReadValid, ReadData, AccInv} !== {1'b0, 16'h4321, 1'b0}) begin bad++; $display("FAIL ram_hold: got %b/%h/%b want 0/4321/0", ReadValid, ReadData, AccInv); end
  endtask

  task automatic test_os_fault();
    wr(16'h2014, 16'h5555, 1'b1);
    total++; if (AccInv !== 1'b0) begin bad++; $display("FAIL os_kwr: got AccInv=%b want 0", AccInv); end
    wr(16'h2014, 16'hDA7A, 1'b0);
    total++; if ({AccInv, FaultAddr} !== {1'b1, 16'h2014}) begin bad++; $display("FAIL os_uwr: got %b/%h want 1/2014", AccInv, FaultAddr); end
    rd(16'h1337, 1'b0);
    total++; if ({ReadValid, ReadData, AccInv, FaultAddr} !== {1'b1, 16'h0, 1'b1, 16'h2014}) begin bad++; $display("FAIL os_urd: got %b/%h/%b/%h want 1/0000/1/2014", ReadValid, ReadData, AccInv, FaultAddr); end
    rd(16'h2014, 1'b1);
    total++; if (ReadData !== 16'h5555) begin bad++; $display("FAIL os_unchanged: got %h want 5555", ReadData); end
    FaultClr = 1'b1;
    wr(16'h2014, 16'hDA7A, 1'b1);
    FaultClr = 1'b0;
    total++; if ({AccInv, FaultAddr} !== 17'h0) begin bad++; $display("FAIL os_clr: got %b/%h want 0/0000", AccInv, FaultAddr); end
    rd(16'h2014, 1'b1);
    total++; if ({ReadValid, ReadData} !== {1'b1, 16'hDA7A}) begin bad++; $display("FAIL os_kread: got %b/%h want 1/DA7A", ReadValid, ReadData); end
  endtask

  task automatic test_out();
    logic [15:0] exp_rb;
`ifdef MEMIO_OUT_READBACK_EN
    exp_rb = 16'hB00B;
`else
    exp_rb = 16'h0000;
`endif
    wr(16'h0002, 16'hB00B, 1'b0);
    total++; if ({Output, OutStrobe} !== {64'h0000_0000_B00B_0000, 4'b0010}) begin bad++; $display("FAIL out_wr: got %h/%b want 00000000B00B0000/0010", Output, OutStrobe); end
    cyc();
    total++; if (OutStrobe !== 4'b0000) begin bad++; $display("FAIL out_strobe_end: got %b want 0000", OutStrobe); end
    rd(16'h0002, 1'b0);
    total++; if ({ReadValid, ReadData, AccInv} !== {1'b1, exp_rb, 1'b0}) begin bad++; $display("FAIL out_rd: got %b/%h/%b want 1/%h/0", ReadValid, ReadData, AccInv, exp_rb); end
  endtask

  task automatic test_fifo();
    logic [15:0] exp_q [4] = '{16'hBEEF, 16'hCAFE, 16'h0001, 16'h0002};
    for (int i = 0; i < 4; i++) push(0, exp_q[i]);
    total++; if ({InputFull[0], InputRecv[0], InputOvf[0]} !== 3'b110) begin bad++; $display("FAIL fifo_full: got full/recv/ovf=%b%b%b want 110", InputFull[0], InputRecv[0], InputOvf[0]); end
    push(0, 16'h0003);
    total++; if (InputOvf[0] !== 1'b1) begin bad++; $display("FAIL fifo_ovf: got %b want 1", InputOvf[0]); end
    for (int i = 0; i < 4; i++) begin
      rd(16'h0100, 1'b0);
      total++; if ({ReadValid, ReadData} !== {1'b1, exp_q[i]}) begin bad++; $display("FAIL fifo_pop%0d: got %b/%h want 1/%h", i, ReadValid, ReadData, exp_q[i]); end
    end
    total++; if ({InputRecv[0], InputFull[0]} !== 2'b00) begin bad++; $display("FAIL fifo_empty: got recv/full=%b%b want 00", InputRecv[0], InputFull[0]); end
    rd(16'h0100, 1'b0);
    total++; if ({ReadValid, ReadData, AccInv} !== {1'b1, 16'h0, 1'b0}) begin bad++; $display("FAIL fifo_empty_rd: got %b/%h/%b want 1/0000/0", ReadValid, ReadData, AccInv); end
    InputRst[0] = 1'b1; cyc(); InputRst = 4'h0;
    total++; if (InputOvf[0] !== 1'b0) begin bad++; $display("FAIL fifo_ovf_clr: got %b want 0", InputOvf[0]); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) push(2, 16'h2001 + 16'(i));
    Input[47:32] = 16'h7777; InputStrobe[2] = 1'b1;
    rd(16'h0104, 1'b0);
    InputStrobe = 4'h0;
    total++; if ({ReadData, InputFull[2], InputOvf[2]} !== {16'h2001, 1'b1, 1'b0}) begin bad++; $display("FAIL full_pushpop: got %h/%b/%b want 2001/1/0", ReadData, InputFull[2], InputOvf[2]); end
    rd(16'h0104, 1'b0);
    total++; if ({ReadData, InputFull[2]} !== {16'h2002, 1'b0}) begin bad++; $display("FAIL full_next: got %h/%b want 2002/0", ReadData, InputFull[2]); end
    Input[47:32] = 16'h8888; InputStrobe[2] = 1'b1; InputRst[2] = 1'b1;
    rd(16'h0104, 1'b0);
    InputStrobe = 4'h0; InputRst = 4'h0;
    total++; if ({ReadData, InputRecv[2], InputFull[2]} !== {16'h0, 1'b0, 1'b0}) begin bad++; $display("FAIL rst_prio: got %h/%b/%b want 0000/0/0", ReadData, InputRecv[2], InputFull[2]); end
    Input[31:16] = 16'h1111; InputStrobe[1] = 1'b1;
    rd(16'h0102, 1'b0);
    InputStrobe = 4'h0;
    total++; if ({ReadData, InputRecv[1]} !== {16'h0, 1'b1}) begin bad++; $display("FAIL empty_pushpop: got %h/%b want 0000/1", ReadData, InputRecv[1]); end
    rd(16'h0102, 1'b0);
    total++; if ({ReadData, InputRecv[1]} !== {16'h1111, 1'b0}) begin bad++; $display("FAIL empty_pushpop2: got %h/%b want 1111/0", ReadData, InputRecv[1]); end
  endtask

  task automatic test_faults();
    rd(16'h4001, 1'b0);
    total++; if ({ReadValid, ReadData, AccInv, FaultAddr} !== {1'b1, 16'h0, 1'b1, 16'h4001}) begin bad++; $display("FAIL odd_rd: got %b/%h/%b/%h want 1/0000/1/4001", ReadValid, ReadData, AccInv, FaultAddr); end
    wr(16'h0100, 16'h5A5A, 1'b1);
    total++; if ({AccInv, FaultAddr} !== {1'b1, 16'h4001}) begin bad++; $display("FAIL in_wr: got %b/%h want 1/4001", AccInv, FaultAddr); end
    FaultClr = 1'b1;
    rd(16'h8000, 1'b1);
    FaultClr = 1'b0;
    total++; if ({AccInv, FaultAddr} !== {1'b1, 16'h8000}) begin bad++; $display("FAIL clr_vs_fault: got %b/%h want 1/8000", AccInv, FaultAddr); end
    clr_fault();
    total++; if ({AccInv, FaultAddr} !== 17'h0) begin bad++; $display("FAIL clr: got %b/%h want 0/0000", AccInv, FaultAddr); end
    wr(16'h47FE, 16'hABCD, 1'b0);
    rd(16'h47FE, 1'b0);
    total++; if ({ReadData, AccInv} !== {16'hABCD, 1'b0}) begin bad++; $display("FAIL ram_top: got %h/%b want ABCD/0", ReadData, AccInv); end
    rd(16'h4800, 1'b0);
    total++; if ({ReadData, AccInv, FaultAddr} !== {16'h0, 1'b1, 16'h4800}) begin bad++; $display("FAIL ram_past: got %h/%b/%h want 0000/1/4800", ReadData, AccInv, FaultAddr); end
    clr_fault();
    Addr = 16'h4004; WriteData = 16'h9999; WriteFlag = 1'b1; ReadFlag = 1'b1;
    cyc();
    WriteFlag = 1'b0; ReadFlag = 1'b0;
    total++; if (ReadValid !== 1'b0) begin bad++; $display("FAIL wr_rd_both: got ReadValid=%b want 0", ReadValid); end
    rd(16'h4004, 1'b0);
    total++; if ({ReadValid, ReadData} !== {1'b1, 16'h9999}) begin bad++; $display("FAIL wr_rd_both_data: got %b/%h want 1/9999", ReadValid, ReadData); end
  endtask

  task automatic test_rst_mid();
    wr(16'h0006, 16'hF00D, 1'b0);
    push(1, 16'h3333);
    rd(16'h0103, 1'b0);
    Addr = 16'h4004; ReadFlag = 1'b1; Rst = 1'b1;
    cyc();
    ReadFlag = 1'b0; Rst = 1'b0;
    total++; if ({ReadValid, ReadData, AccInv, FaultAddr} !== 34'h0) begin bad++; $display("FAIL rst_mid_rd: got %b/%h/%b/%h want 0", ReadValid, ReadData, AccInv, FaultAddr); end
    total++; if ({Output, OutStrobe, InputRecv, InputFull, InputOvf} !== 80'h0) begin bad++; $display("FAIL rst_mid_io: got %h/%b/%b want 0", Output, OutStrobe, InputRecv); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_os_fault();
    test_out();
    test_fifo();
    test_back_to_back();
    test_faults();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
